// File: rtl/j1_pkg.sv
// Shared definitions for the J1 boot loader: FSM states and frame layout constants.
package j1_pkg;

    // Loader FSM states, one per frame field.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR_H,
        ST_ADDR_L,
        ST_CNT_H,
        ST_CNT_L,
        ST_DATA_L,
        ST_DATA_H,
        ST_CSUM
    } loader_state_e;

    // Default frame start marker.
    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

    // Frame overhead: SYNC + ADDR_H + ADDR_L + CNT_H + CNT_L, then one checksum byte.
    localparam int unsigned HDR_BYTES  = 5;
    localparam int unsigned CSUM_BYTES = 1;

endpackage

// File: rtl/j1_boot_timeout.sv
// Idle-cycle counter for the boot loader: cleared on activity, counts while enabled,
// flags expiry once LIMIT idle cycles have elapsed. LIMIT of 0 disables expiry.
module j1_boot_timeout #(
    parameter int unsigned LIMIT = 1000000
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int unsigned   CW      = (LIMIT > 1) ? $clog2(LIMIT + 1) : 1;
    localparam logic [CW-1:0] LIMIT_V = CW'(LIMIT);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          hit;

    // Next count: clear wins, otherwise count up and saturate at the limit.
    always_comb begin
        hit   = (LIMIT != 0) && (cnt_q == LIMIT_V);
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && !hit && (LIMIT != 0)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = hit;

endmodule

// File: rtl/j1_boot_loader.sv
// J1 program loader: parses framed byte stream, writes 16-bit little-endian words
// into the CPU instruction RAM and holds the CPU in reset until a frame verifies.
module j1_boot_loader
    import j1_pkg::*;
#(
    parameter logic [7:0]  SYNC_BYTE   = SYNC_BYTE_DEFAULT,
    parameter int unsigned TIMEOUT_CYC = 1000000,
    parameter bit          BOOT_HOLD   = 1'b1
) (
    input  logic        sys_clk_i,
    input  logic        sys_rst_n_i,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_valid_i,
    output logic        rx_ready_o,
    output logic [15:0] pgm_addr_o,
    output logic [15:0] pgm_data_o,
    output logic        pgm_we_o,
    output logic        cpu_rst_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o
);

    loader_state_e state_q, state_d;
    logic [15:0]   addr_q, addr_d;
    logic [15:0]   cnt_q, cnt_d;
    logic [7:0]    lo_q, lo_d;
    logic [7:0]    sum_q, sum_d;
    logic [15:0]   pgm_addr_q, pgm_addr_d;
    logic [15:0]   pgm_data_q, pgm_data_d;
    logic          pgm_we_q, pgm_we_d;
    logic          cpu_rst_q, cpu_rst_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          rdy_q;

    logic          accept;
    logic [7:0]    sum_next;
    logic          tmo_expired;

    assign accept   = rx_valid_i & rdy_q;
    assign sum_next = sum_q + rx_data_i;

    j1_boot_timeout #(
        .LIMIT (TIMEOUT_CYC)
    ) u_timeout (
        .clk_i     (sys_clk_i),
        .rst_n_i   (sys_rst_n_i),
        .clr_i     (accept | ~busy_q),
        .en_i      (busy_q),
        .expired_o (tmo_expired)
    );

    // Next-state and datapath decode; timeout abort takes priority over a byte.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        lo_d       = lo_q;
        sum_d      = sum_q;
        pgm_addr_d = pgm_addr_q;
        pgm_data_d = pgm_data_q;
        pgm_we_d   = 1'b0;
        cpu_rst_d  = cpu_rst_q;
        busy_d     = busy_q;
        done_d     = done_q;
        err_d      = err_q;

        if (busy_q && tmo_expired) begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            err_d   = 1'b1;
        end else if (accept) begin
            case (state_q)
                ST_IDLE: begin
                    if (rx_data_i == SYNC_BYTE) begin
                        state_d   = ST_ADDR_H;
                        busy_d    = 1'b1;
                        cpu_rst_d = 1'b1;
                        done_d    = 1'b0;
                        err_d     = 1'b0;
                        sum_d     = '0;
                    end
                end
                ST_ADDR_H: begin
                    addr_d[15:8] = rx_data_i;
                    sum_d        = sum_next;
                    state_d      = ST_ADDR_L;
                end
                ST_ADDR_L: begin
                    addr_d[7:0] = {rx_data_i[7:1], 1'b0};
                    sum_d       = sum_next;
                    state_d     = ST_CNT_H;
                end
                ST_CNT_H: begin
                    cnt_d[15:8] = rx_data_i;
                    sum_d       = sum_next;
                    state_d     = ST_CNT_L;
                end
                ST_CNT_L: begin
                    cnt_d[7:0] = rx_data_i;
                    sum_d      = sum_next;
                    state_d    = ({cnt_q[15:8], rx_data_i} == 16'd0) ? ST_CSUM : ST_DATA_L;
                end
                ST_DATA_L: begin
                    lo_d    = rx_data_i;
                    sum_d   = sum_next;
                    state_d = ST_DATA_H;
                end
                ST_DATA_H: begin
                    pgm_we_d   = 1'b1;
                    pgm_data_d = {rx_data_i, lo_q};
                    pgm_addr_d = addr_q;
                    addr_d     = addr_q + 16'd2;
                    cnt_d      = cnt_q - 16'd1;
                    sum_d      = sum_next;
                    state_d    = (cnt_q == 16'd1) ? ST_CSUM : ST_DATA_L;
                end
                ST_CSUM: begin
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                    if (sum_next == 8'h00) begin
                        done_d    = 1'b1;
                        cpu_rst_d = 1'b0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State and output registers; reset drops any pending write strobe.
    always_ff @(posedge sys_clk_i) begin
        if (!sys_rst_n_i) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            cnt_q      <= '0;
            lo_q       <= '0;
            sum_q      <= '0;
            pgm_addr_q <= '0;
            pgm_data_q <= '0;
            pgm_we_q   <= 1'b0;
            cpu_rst_q  <= BOOT_HOLD;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            rdy_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            lo_q       <= lo_d;
            sum_q      <= sum_d;
            pgm_addr_q <= pgm_addr_d;
            pgm_data_q <= pgm_data_d;
            pgm_we_q   <= pgm_we_d;
            cpu_rst_q  <= cpu_rst_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            rdy_q      <= 1'b1;
        end
    end

    assign rx_ready_o = rdy_q;
    assign pgm_addr_o = pgm_addr_q;
    assign pgm_data_o = pgm_data_q;
    assign pgm_we_o   = pgm_we_q;
    assign cpu_rst_o  = cpu_rst_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign err_o      = err_q;

endmodule

// File: tb/tb_j1_boot_loader.sv
// Scoreboard bench for j1_boot_loader: stimulus pushes expected writes and
// end-of-frame status; monitors pop and compare when the DUT presents them.
module tb_j1_boot_loader;
    import j1_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [15:0] pgm_addr;
    logic [15:0] pgm_data;
    logic        pgm_we;
    logic        cpu_rst;
    logic        busy;
    logic        done;
    logic        err;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] wq[$];   // expected writes {addr, data}
    logic [2:0]  sq[$];   // expected status at frame end {done, err, cpu_rst}
    logic [7:0]  fr[$];   // frame being sent

    j1_boot_loader #(
        .SYNC_BYTE   (8'hA5),
        .TIMEOUT_CYC (16),
        .BOOT_HOLD   (1'b1)
    ) dut (
        .sys_clk_i   (clk),
        .sys_rst_n_i (rst_n),
        .rx_data_i   (rx_data),
        .rx_valid_i  (rx_valid),
        .rx_ready_o  (rx_ready),
        .pgm_addr_o  (pgm_addr),
        .pgm_data_o  (pgm_data),
        .pgm_we_o    (pgm_we),
        .cpu_rst_o   (cpu_rst),
        .busy_o      (busy),
        .done_o      (done),
        .err_o       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic send_fr();
        foreach (fr[i]) send_byte(fr[i]);
        rx_valid = 1'b0;
    endtask

    task automatic gap(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Write monitor: every strobe must match the next expected write.
    logic prev_we = 1'b0;
    always @(negedge clk) begin
        if (pgm_we === 1'b1) begin
            if (prev_we) check("we_single_cycle", 32'd1, 32'd0);
            if (wq.size() == 0) begin
                check("unexpected_write", {pgm_addr, pgm_data}, 32'hFFFF_FFFF);
            end else begin
                logic [31:0] e;
                e = wq.pop_front();
                check("write_addr", {16'h0, pgm_addr}, {16'h0, e[31:16]});
                check("write_data", {16'h0, pgm_data}, {16'h0, e[15:0]});
            end
        end
        prev_we = (pgm_we === 1'b1);
    end

    // Status monitor: when busy falls, compare done/err/cpu_rst.
    logic prev_busy = 1'b0;
    always @(negedge clk) begin
        if (prev_busy && busy === 1'b0) begin
            if (sq.size() == 0) begin
                check("unexpected_frame_end", {29'h0, done, err, cpu_rst}, 32'hFFFF_FFFF);
            end else begin
                logic [2:0] e;
                e = sq.pop_front();
                check("frame_status", {29'h0, done, err, cpu_rst}, {29'h0, e});
            end
        end
        prev_busy = (busy === 1'b1);
    end

    // Watchdog so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        gap(3);
        check("rst_rx_ready", {31'h0, rx_ready}, 32'd0);
        check("rst_pgm_we",   {31'h0, pgm_we},   32'd0);
        check("rst_pgm_addr", {16'h0, pgm_addr}, 32'd0);
        check("rst_pgm_data", {16'h0, pgm_data}, 32'd0);
        check("rst_busy",     {31'h0, busy},     32'd0);
        check("rst_done",     {31'h0, done},     32'd0);
        check("rst_err",      {31'h0, err},      32'd0);
        check("rst_cpu_rst",  {31'h0, cpu_rst},  32'd1);
        rst_n = 1'b1;
        gap(1);
        check("rx_ready_after_reset", {31'h0, rx_ready}, 32'd1);

        // Leading garbage ignored, then a good two-word frame (checksum 0xDA).
        fr = {8'h00, 8'hFF, 8'h5A};
        send_fr();
        gap(2);
        check("garbage_ignored_busy", {31'h0, busy}, 32'd0);
        wq.push_back(32'h0010_1234);
        wq.push_back(32'h0012_5678);
        sq.push_back(3'b100);
        fr = {8'hA5, 8'h00, 8'h10, 8'h00, 8'h02, 8'h34, 8'h12, 8'h78, 8'h56, 8'hDA};
        send_fr();
        gap(2);
        check("good_cpu_rst", {31'h0, cpu_rst}, 32'd0);

        // Same frame with a bad checksum: writes still occur, CPU stays in reset.
        wq.push_back(32'h0010_1234);
        wq.push_back(32'h0012_5678);
        sq.push_back(3'b011);
        fr = {8'hA5, 8'h00, 8'h10, 8'h00, 8'h02, 8'h34, 8'h12, 8'h78, 8'h56, 8'hDB};
        send_fr();
        gap(2);

        // Zero-count frame.
        sq.push_back(3'b100);
        fr = {8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        send_fr();
        gap(2);

        // Address wrap 0xFFFE -> 0x0000 (sum of payload 0xA9, checksum 0x57).
        wq.push_back(32'hFFFE_2211);
        wq.push_back(32'h0000_4433);
        sq.push_back(3'b100);
        fr = {8'hA5, 8'hFF, 8'hFE, 8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h57};
        send_fr();
        gap(2);

        // Odd address forced even, SYNC value used as data (checksum 0x94).
        wq.push_back(32'h0020_A5A5);
        sq.push_back(3'b100);
        fr = {8'hA5, 8'h00, 8'h21, 8'h00, 8'h01, 8'hA5, 8'hA5, 8'h94};
        send_fr();
        gap(2);

        // Timeout: stall after the address bytes.
        sq.push_back(3'b011);
        fr = {8'hA5, 8'h00, 8'h10};
        send_fr();
        gap(16);
        check("tmo_still_busy", {31'h0, busy}, 32'd1);
        gap(1);
        check("tmo_busy", {31'h0, busy}, 32'd0);
        check("tmo_err", {31'h0, err}, 32'd1);
        check("tmo_cpu_rst", {31'h0, cpu_rst}, 32'd1);
        gap(2);

        // Loader recovers with a good frame.
        wq.push_back(32'h0010_1234);
        wq.push_back(32'h0012_5678);
        sq.push_back(3'b100);
        fr = {8'hA5, 8'h00, 8'h10, 8'h00, 8'h02, 8'h34, 8'h12, 8'h78, 8'h56, 8'hDA};
        send_fr();
        gap(2);

        // Reset coinciding with the high data byte: the pending strobe is dropped.
        sq.push_back(3'b001);
        fr = {8'hA5, 8'h00, 8'h10, 8'h00, 8'h02, 8'h34};
        send_fr();
        rst_n = 1'b0;
        send_byte(8'h12);
        rx_valid = 1'b0;
        rst_n    = 1'b1;
        check("mid_rst_rx_ready", {31'h0, rx_ready}, 32'd0);
        check("mid_rst_pgm_we",   {31'h0, pgm_we},   32'd0);
        check("mid_rst_pgm_addr", {16'h0, pgm_addr}, 32'd0);
        check("mid_rst_pgm_data", {16'h0, pgm_data}, 32'd0);
        check("mid_rst_busy",     {31'h0, busy},     32'd0);
        check("mid_rst_done",     {31'h0, done},     32'd0);
        check("mid_rst_err",      {31'h0, err},      32'd0);
        check("mid_rst_cpu_rst",  {31'h0, cpu_rst},  32'd1);
        gap(20);

        check("writes_pending", wq.size(), 32'd0);
        check("status_pending", sq.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
